// File: rtl/alu_req_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU front end.
package alu_req_arbiter_pkg;

  // Controller states: idle/arbitrating, waiting on the ALU, holding a response.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // ALU_FUN[3:2] selects which ALU sub-block produces the result.
  localparam logic [1:0] FUN_ARITH = 2'b00;
  localparam logic [1:0] FUN_LOGIC = 2'b01;
  localparam logic [1:0] FUN_CMP   = 2'b10;
  localparam logic [1:0] FUN_SHIFT = 2'b11;

endpackage

// File: rtl/alu_req_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins; on a tie the
// requester that was not granted last time wins.
module rr_arbiter2
  import alu_req_arbiter_pkg::*;
(
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // One-hot grant, all-zero when nobody is requesting.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU_Top between two requesters: round-robin accept, drive the
// ALU operands, wait out the ALU latency, capture the selected sub-block
// result and return it with the requester id.
module alu_req_arbiter
  import alu_req_arbiter_pkg::*;
#(
  parameter int IN_DATA_WIDTH = 16,
  parameter int OP_DATA_WIDTH = 32,
  parameter int ALU_LATENCY   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [2*IN_DATA_WIDTH-1:0] req_a,
  input  logic [2*IN_DATA_WIDTH-1:0] req_b,
  input  logic [7:0]                 req_fun,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_id,
  output logic [OP_DATA_WIDTH-1:0]   rsp_data,
  output logic                       rsp_carry,
  output logic                       rsp_flag,
  output logic                       busy,
  output logic [IN_DATA_WIDTH-1:0]   alu_a,
  output logic [IN_DATA_WIDTH-1:0]   alu_b,
  output logic [3:0]                 alu_fun,
  input  logic [OP_DATA_WIDTH-1:0]   alu_arith_out,
  input  logic                       alu_carry_out,
  input  logic                       alu_arith_flag,
  input  logic [IN_DATA_WIDTH-1:0]   alu_logic_out,
  input  logic                       alu_logic_flag,
  input  logic [IN_DATA_WIDTH-1:0]   alu_cmp_out,
  input  logic                       alu_cmp_flag,
  input  logic [IN_DATA_WIDTH-1:0]   alu_shift_out,
  input  logic                       alu_shift_flag
);

  // Counter must reach ALU_LATENCY; it restarts at zero on every accept.
  localparam int CNT_W = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);

  state_t           state;
  logic             last_grant;
  logic [1:0]       grant;
  logic             winner;
  logic             accept;
  logic             id_q;
  logic [1:0]       fun_class;
  logic [CNT_W-1:0] cnt;

  rr_arbiter2 u_rr (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Grant is only offered while idle, so EXEC/RESP never accept.
  assign req_ready = (state == ST_IDLE) ? grant : 2'b00;
  assign accept    = |req_ready;
  assign winner    = grant[1];
  assign busy      = (state != ST_IDLE);

  // Sequencer: accept -> drive ALU -> capture after latency -> hold response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      fun_class  <= FUN_ARITH;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_fun    <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_carry  <= 1'b0;
      rsp_flag   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            alu_a      <= winner ? req_a[2*IN_DATA_WIDTH-1:IN_DATA_WIDTH] : req_a[IN_DATA_WIDTH-1:0];
            alu_b      <= winner ? req_b[2*IN_DATA_WIDTH-1:IN_DATA_WIDTH] : req_b[IN_DATA_WIDTH-1:0];
            alu_fun    <= winner ? req_fun[7:4] : req_fun[3:0];
            fun_class  <= winner ? req_fun[7:6] : req_fun[3:2];
            id_q       <= winner;
            last_grant <= winner;
            cnt        <= '0;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt == CNT_W'(ALU_LATENCY)) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            rsp_carry <= 1'b0;
            case (fun_class)
              FUN_ARITH: begin
                rsp_data  <= alu_arith_out;
                rsp_carry <= alu_carry_out;
                rsp_flag  <= alu_arith_flag;
              end
              FUN_LOGIC: begin
                rsp_data <= OP_DATA_WIDTH'(alu_logic_out);
                rsp_flag <= alu_logic_flag;
              end
              FUN_CMP: begin
                rsp_data <= OP_DATA_WIDTH'(alu_cmp_out);
                rsp_flag <= alu_cmp_flag;
              end
              default: begin
                rsp_data <= OP_DATA_WIDTH'(alu_shift_out);
                rsp_flag <= alu_shift_flag;
              end
            endcase
            state <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: behavioural ALU stand-in, transaction-level
// reference model, directed scenarios, random traffic, and a latency-3 build.
module tb_alu_req_arbiter;

  localparam int IW  = 16;
  localparam int OW  = 32;
  localparam int LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (latency 1)
  logic          rst;
  logic [1:0]    req_valid, req_ready;
  logic [31:0]   req_a, req_b;
  logic [7:0]    req_fun;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_flag, busy;
  logic [31:0]   rsp_data;
  logic [15:0]   alu_a, alu_b;
  logic [3:0]    alu_fun;
  logic [31:0]   alu_arith_out;
  logic          alu_carry_out, alu_arith_flag, alu_logic_flag, alu_cmp_flag, alu_shift_flag;
  logic [15:0]   alu_logic_out, alu_cmp_out, alu_shift_out;

  // Second DUT (latency 3)
  logic          rst3;
  logic [1:0]    req_valid3, req_ready3;
  logic [31:0]   req_a3, req_b3;
  logic [7:0]    req_fun3;
  logic          rsp_valid3, rsp_ready3, rsp_id3, rsp_carry3, rsp_flag3, busy3;
  logic [31:0]   rsp_data3;
  logic [15:0]   alu_a3, alu_b3;
  logic [3:0]    alu_fun3;

  typedef struct packed {
    logic [31:0] arith; logic carry; logic aflag;
    logic [15:0] lo;    logic lflag;
    logic [15:0] co;    logic cflag;
    logic [15:0] so;    logic sflag;
  } alu_o_t;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic        carry;
    logic        flag;
  } rsp_t;

  // Behavioural ALU: every sub-block always produces a (distinct) value.
  function automatic alu_o_t alu_fn(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun);
    alu_o_t r;
    logic [16:0] s;
    r = '0;
    case (fun[1:0])
      2'd0: begin s = {1'b0, a} + {1'b0, b}; r.arith = {15'd0, s}; r.carry = s[16]; end
      2'd1: begin s = {1'b0, a} - {1'b0, b}; r.arith = {16'd0, s[15:0]}; r.carry = s[16]; end
      2'd2: r.arith = {16'd0, a} * {16'd0, b};
      default: r.arith = (b == 16'd0) ? 32'd0 : {16'd0, a / b};
    endcase
    r.aflag = r.arith[0] ^ fun[0];
    case (fun[1:0])
      2'd0: r.lo = a & b;
      2'd1: r.lo = a | b;
      2'd2: r.lo = ~(a & b);
      default: r.lo = ~(a | b);
    endcase
    r.lflag = ^r.lo;
    case (fun[1:0])
      2'd0: r.co = 16'd0;
      2'd1: r.co = (a == b) ? 16'd1 : 16'd0;
      2'd2: r.co = (a > b) ? 16'd2 : 16'd0;
      default: r.co = (a < b) ? 16'd3 : 16'd0;
    endcase
    r.cflag = (r.co != 16'd0);
    case (fun[1:0])
      2'd0: r.so = a >> 1;
      2'd1: r.so = a << 1;
      2'd2: r.so = b >> 1;
      default: r.so = b << 1;
    endcase
    r.sflag = r.so[15];
    return r;
  endfunction

  // What the requester must get back for an op, straight from its operands.
  function automatic rsp_t exp_rsp(input logic id, input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun);
    alu_o_t r;
    rsp_t e;
    r = alu_fn(a, b, fun);
    e.id = id;
    e.carry = 1'b0;
    case (fun[3:2])
      2'b00: begin e.data = r.arith; e.carry = r.carry; e.flag = r.aflag; end
      2'b01: begin e.data = {16'd0, r.lo}; e.flag = r.lflag; end
      2'b10: begin e.data = {16'd0, r.co}; e.flag = r.cflag; end
      default: begin e.data = {16'd0, r.so}; e.flag = r.sflag; end
    endcase
    return e;
  endfunction

  // ALU stand-ins with registered latency
  logic [35:0] pipe1 [LAT];
  logic [35:0] pipe3 [3];
  alu_o_t o1, o3;

  always @(posedge clk) begin
    pipe1[0] <= {alu_a, alu_b, alu_fun};
    for (int i = 1; i < LAT; i++) pipe1[i] <= pipe1[i-1];
  end
  always @(posedge clk) begin
    pipe3[0] <= {alu_a3, alu_b3, alu_fun3};
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign o1 = alu_fn(pipe1[LAT-1][35:20], pipe1[LAT-1][19:4], pipe1[LAT-1][3:0]);
  assign o3 = alu_fn(pipe3[2][35:20], pipe3[2][19:4], pipe3[2][3:0]);

  assign alu_arith_out  = o1.arith;
  assign alu_carry_out  = o1.carry;
  assign alu_arith_flag = o1.aflag;
  assign alu_logic_out  = o1.lo;
  assign alu_logic_flag = o1.lflag;
  assign alu_cmp_out    = o1.co;
  assign alu_cmp_flag   = o1.cflag;
  assign alu_shift_out  = o1.so;
  assign alu_shift_flag = o1.sflag;

  alu_req_arbiter #(.IN_DATA_WIDTH(IW), .OP_DATA_WIDTH(OW), .ALU_LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_fun(req_fun),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_flag(rsp_flag), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
    .alu_arith_out(alu_arith_out), .alu_carry_out(alu_carry_out), .alu_arith_flag(alu_arith_flag),
    .alu_logic_out(alu_logic_out), .alu_logic_flag(alu_logic_flag),
    .alu_cmp_out(alu_cmp_out), .alu_cmp_flag(alu_cmp_flag),
    .alu_shift_out(alu_shift_out), .alu_shift_flag(alu_shift_flag)
  );

  alu_req_arbiter #(.IN_DATA_WIDTH(IW), .OP_DATA_WIDTH(OW), .ALU_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst3), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .req_fun(req_fun3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3), .rsp_data(rsp_data3),
    .rsp_carry(rsp_carry3), .rsp_flag(rsp_flag3), .busy(busy3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_fun(alu_fun3),
    .alu_arith_out(o3.arith), .alu_carry_out(o3.carry), .alu_arith_flag(o3.aflag),
    .alu_logic_out(o3.lo), .alu_logic_flag(o3.lflag),
    .alu_cmp_out(o3.co), .alu_cmp_flag(o3.cflag),
    .alu_shift_out(o3.so), .alu_shift_flag(o3.sflag)
  );

  // Reference model state (transaction level)
  int          n_checks = 0;
  int          n_err = 0;
  bit          m_busy, m_last, m_zero;
  int          m_age;
  logic [15:0] m_a, m_b;
  logic [3:0]  m_fun;
  rsp_t        m_exp;
  bit          n_acc, n_hs, n_rst;
  int          w;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model in the middle of the cycle.
  task automatic sample();
    logic [1:0] er;
    logic       erv;
    @(negedge clk);
    if (!m_busy) begin
      case (req_valid)
        2'b01:   w = 0;
        2'b10:   w = 1;
        2'b11:   w = m_last ? 0 : 1;
        default: w = -1;
      endcase
      er  = (w < 0) ? 2'b00 : ((w == 0) ? 2'b01 : 2'b10);
      erv = 1'b0;
    end else begin
      er  = 2'b00;
      erv = (m_age >= LAT + 2);
    end
    chk("req_ready", req_ready, er);
    chk("busy", busy, m_busy);
    chk("rsp_valid", rsp_valid, erv);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_fun", alu_fun, m_fun);
    if (erv) begin
      chk("rsp_id", rsp_id, m_exp.id);
      chk("rsp_data", rsp_data, m_exp.data);
      chk("rsp_carry", rsp_carry, m_exp.carry);
      chk("rsp_flag", rsp_flag, m_exp.flag);
    end else if (m_zero) begin
      chk("rsp_id_rst", rsp_id, 0);
      chk("rsp_data_rst", rsp_data, 0);
      chk("rsp_carry_rst", rsp_carry, 0);
      chk("rsp_flag_rst", rsp_flag, 0);
    end
    n_rst = rst;
    n_acc = (er != 2'b00);
    n_hs  = erv && rsp_ready;
  endtask

  // Step the model across the clock edge, then release inputs for driving.
  task automatic advance();
    @(posedge clk);
    if (n_rst) begin
      m_busy = 0; m_last = 1; m_zero = 1;
      m_a = '0; m_b = '0; m_fun = '0;
    end else if (n_acc) begin
      m_busy = 1;
      m_age  = 1;
      m_last = w[0];
      m_a    = w[0] ? req_a[31:16] : req_a[15:0];
      m_b    = w[0] ? req_b[31:16] : req_b[15:0];
      m_fun  = w[0] ? req_fun[7:4] : req_fun[3:0];
      m_exp  = exp_rsp(w[0], m_a, m_b, m_fun);
      m_zero = 0;
    end else if (m_busy) begin
      if (n_hs) m_busy = 0;
      else m_age++;
    end
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  // Requester behaviour: hold until accepted, may drop early, new op after accept.
  task automatic drive_rand(input int p_new, input int p_keep, input bit force_fun, input logic [3:0] ffun);
    for (int i = 0; i < 2; i++) begin
      bit acc_i;
      logic [15:0] a, b;
      acc_i = n_acc && !n_rst && (w == i);
      if (req_valid[i] && !acc_i) begin
        if (int'($urandom_range(99)) >= p_keep) req_valid[i] = 1'b0;
      end else if (int'($urandom_range(99)) < p_new) begin
        a = 16'($urandom);
        b = ($urandom_range(3) == 0) ? a : 16'($urandom);
        if ($urandom_range(3) == 0) b = 16'($urandom_range(7));
        req_valid[i] = 1'b1;
        req_a[i*16 +: 16] = a;
        req_b[i*16 +: 16] = b;
        req_fun[i*4 +: 4] = force_fun ? ffun : 4'($urandom);
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic drain();
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    for (int c = 0; c < 20 && m_busy; c++) step();
    sample();
    chk("drain_idle", busy, 0);
    advance();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1; rst3 = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; req_fun = '0; rsp_ready = 1'b1;
    req_valid3 = '0; req_a3 = '0; req_b3 = '0; req_fun3 = '0; rsp_ready3 = 1'b1;
    n_rst = 1; n_acc = 0; n_hs = 0; w = -1;
    advance();
    advance();
    rst = 1'b0;

    // Hand-computed anchors for the model itself
    chk("pin_add", exp_rsp(1'b0, 16'd7, 16'd5, 4'b0000).data, 32'd12);
    chk("pin_add_c", exp_rsp(1'b0, 16'd7, 16'd5, 4'b0000).carry, 0);
    chk("pin_cmp", exp_rsp(1'b1, 16'd9, 16'd9, 4'b1001).data, 32'h1);
    chk("pin_cmp_f", exp_rsp(1'b1, 16'd9, 16'd9, 4'b1001).flag, 1);
    chk("pin_sub", exp_rsp(1'b0, 16'd20, 16'd3, 4'b0001).data, 32'd17);
    chk("pin_shl_c", exp_rsp(1'b0, 16'hFFFF, 16'h1, 4'b1101).carry, 0);

    // Reset state
    sample();
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp_data", rsp_data, 0);
    advance();

    // Single req0 add: accepted at T, response at T+3
    req_valid = 2'b01; req_a = 32'd7; req_b = 32'd5; req_fun = 8'h00;
    sample(); chk("t1_ready", req_ready, 2'b01); advance();
    req_valid = 2'b00;
    sample(); chk("t1_rv_t1", rsp_valid, 0); advance();
    sample(); chk("t1_rv_t2", rsp_valid, 0); advance();
    sample();
    chk("t1_rv_t3", rsp_valid, 1);
    chk("t1_data", rsp_data, 32'd12);
    chk("t1_id", rsp_id, 0);
    chk("t1_carry", rsp_carry, 0);
    advance();
    step();

    // Both valid continuously: grants alternate starting with req0
    do_reset();
    k = 0;
    for (int c = 0; c < 60 && k < 4; c++) begin
      drive_rand(100, 100, 1'b1, 4'b0100);
      sample();
      if (n_hs) begin
        chk("t2_id_order", rsp_id, k % 2);
        k++;
      end
      advance();
    end
    chk("t2_count", k, 4);
    drain();

    // CMP on req1
    req_valid = 2'b10; req_a = {16'd9, 16'd0}; req_b = {16'd9, 16'd0}; req_fun = 8'h90;
    sample(); chk("t3_ready", req_ready, 2'b10); advance();
    req_valid = 2'b00;
    repeat (2) step();
    sample();
    chk("t3_rv", rsp_valid, 1);
    chk("t3_data", rsp_data, 32'h1);
    chk("t3_flag", rsp_flag, 1);
    chk("t3_carry", rsp_carry, 0);
    chk("t3_id", rsp_id, 1);
    advance();
    step();

    // Backpressure: response held for 10 cycles with req1 waiting
    rsp_ready = 1'b0;
    req_valid = 2'b01; req_a = 32'd20; req_b = 32'd3; req_fun = 8'h01;
    step();
    req_valid = 2'b10; req_a = {16'd44, 16'd20}; req_b = {16'd2, 16'd3}; req_fun = 8'h21;
    repeat (2) step();
    for (int j = 0; j < 10; j++) begin
      sample();
      chk("t4_rv_hold", rsp_valid, 1);
      chk("t4_data_hold", rsp_data, 32'd17);
      chk("t4_ready_low", req_ready, 2'b00);
      chk("t4_alu_a_hold", alu_a, 16'd20);
      chk("t4_alu_fun_hold", alu_fun, 4'b0001);
      advance();
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    step();
    drain();

    // Reset during EXEC drops the op; then req1-only, then a tie goes to req0
    req_valid = 2'b01; req_a = 32'd1; req_b = 32'd2; req_fun = 8'h00;
    step();
    req_valid = 2'b00;
    rst = 1'b1;
    step();
    rst = 1'b0;
    sample();
    chk("t5_busy", busy, 0);
    chk("t5_rv", rsp_valid, 0);
    chk("t5_alu_a", alu_a, 0);
    chk("t5_alu_fun", alu_fun, 0);
    chk("t5_data", rsp_data, 0);
    advance();
    req_valid = 2'b10; req_a = {16'd5, 16'd0}; req_b = {16'd6, 16'd0}; req_fun = 8'h40;
    sample(); chk("t5_req1_ready", req_ready, 2'b10); advance();
    req_valid = 2'b00;
    repeat (4) step();
    req_valid = 2'b11; req_a = {16'd5, 16'd8}; req_b = {16'd6, 16'd9}; req_fun = 8'h42;
    sample(); chk("t5_tie_req0", req_ready, 2'b01); advance();
    drain();

    // Random traffic with random backpressure and occasional reset
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(299) == 0);
      rsp_ready = ($urandom_range(99) < 70);
      drive_rand(30, 95, 1'b0, 4'b0000);
      step();
    end
    rst = 1'b0;
    drain();

    // Latency-3 build: response at T+5 carrying the delayed ALU output
    rst3 = 1'b0;
    req_valid3 = 2'b01; req_a3 = 32'd100; req_b3 = 32'd3; req_fun3 = 8'h02;
    @(negedge clk);
    chk("t7_ready", req_ready3, 2'b01);
    @(posedge clk); #1;
    req_valid3 = 2'b00;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      chk("t7_rv", rsp_valid3, (j == 5));
      chk("t7_busy", busy3, 1);
      if (j == 5) begin
        chk("t7_data", rsp_data3, 32'd300);
        chk("t7_id", rsp_id3, 0);
        chk("t7_carry", rsp_carry3, 0);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("t7_idle", busy3, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
Shares one ALU_Top instance between two requesters. Each requester issues {A, B, ALU_FUN} with a valid/ready handshake. The block arbitrates round-robin, drives the ALU operands, waits out the ALU's registered latency, then captures the result from the enabled sub-block. It returns the result with the requester ID over a single valid/ready response channel. It sits directly in front of ALU_Top, on the same clk/rst.

Parameters:
IN_DATA_WIDTH, 16, operand width (matches ALU_Top)
OP_DATA_WIDTH, 32, result width (matches ALU_Top Arith_OUT)
ALU_LATENCY, 1, ALU input-to-output delay in clock cycles (≥1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  2  per-requester request valid, bit i = requester i
req_ready  out  2  per-requester accept, at most one bit set
req_a  in  2*IN_DATA_WIDTH  operand A; requester i in slice [i*IN_DATA_WIDTH +: IN_DATA_WIDTH]
req_b  in  2*IN_DATA_WIDTH  operand B, same packing
req_fun  in  8  ALU_FUN; requester i in [i*4 +: 4]
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  1  requester index of the response
rsp_data  out  OP_DATA_WIDTH  result; non-arith results zero-extended
rsp_carry  out  1  Carry_OUT for arith ops, else 0
rsp_flag  out  1  flag of the selected sub-block
busy  out  1  high whenever state != IDLE
alu_a  out  IN_DATA_WIDTH  to ALU_Top A
alu_b  out  IN_DATA_WIDTH  to ALU_Top B
alu_fun  out  4  to ALU_Top ALU_FUN
alu_arith_out  in  OP_DATA_WIDTH  from Arith_OUT
alu_carry_out  in  1  from Carry_OUT
alu_arith_flag  in  1  from Arith_Flag
alu_logic_out  in  IN_DATA_WIDTH  from Logic_OUT
alu_logic_flag  in  1  from Logic_Flag
alu_cmp_out  in  IN_DATA_WIDTH  from CMP_OUT
alu_cmp_flag  in  1  from CMP_Flag
alu_shift_out  in  IN_DATA_WIDTH  from SHIFT_OUT
alu_shift_flag  in  1  from SHIFT_Flag

Behaviour:
- Reset (rst high at a clk edge): state=IDLE; req_ready=0; rsp_valid=0; rsp_id=0; rsp_data=0; rsp_carry=0; rsp_flag=0; alu_a=0; alu_b=0; alu_fun=0; cycle counter=0; last_grant=1, so requester 0 wins the first tie. Reset mid-operation drops any in-flight op and any pending response, with no partial response.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - req_ready is combinational: the winner's bit is set if its req_valid=1.
  - Winner: if only one requester is valid, that one; if both are valid, the one != last_grant.
  - Handshake at edge T: latch alu_a/alu_b/alu_fun from the winner's slices; latch id and fun[3:2] internally; last_grant<=winner; counter<=0; go to EXEC.
- EXEC:
  - alu_* are registered and held stable from T+1 until the next accept.
  - The counter increments each cycle. When counter==ALU_LATENCY, capture the result at that edge and go to RESP.
  - EXEC occupies ALU_LATENCY+1 cycles. With ALU_LATENCY=1, rsp_valid rises in cycle T+3.
- Capture select, by latched fun[3:2]:
  - 00 arith: data=alu_arith_out; carry=alu_carry_out; flag=alu_arith_flag.
  - 01 logic: data={zeros, alu_logic_out}; flag=alu_logic_flag.
  - 10 cmp: data={zeros, alu_cmp_out}; flag=alu_cmp_flag.
  - 11 shift: data={zeros, alu_shift_out}; flag=alu_shift_flag.
  - carry=0 for every non-arith op.
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_ready=1 at an edge.
  - On that edge: rsp_valid<=0; go to IDLE.
  - req_ready=0 throughout EXEC and RESP, so a new op is never accepted in the RESP-exit cycle.
- Throughput: one op per ALU_LATENCY+3 cycles minimum (accept cycle, EXEC, RESP).
- Requester rules:
  - A requester keeps req_valid and its operands stable until it sees req_ready.
  - Operand changes after acceptance have no effect.
  - Deasserting req_valid before acceptance is legal; that request is simply not granted.
- Backpressure: rsp_ready held low keeps the block in RESP indefinitely. The ALU is not reissued meanwhile.
- busy=0 only in IDLE.

Decomposition:
- Shared package: state encoding (IDLE/EXEC/RESP), ALU_FUN[3:2] class constants (ARITH=2'b00, LOGIC=2'b01, CMP=2'b10, SHIFT=2'b11).
- One natural sub-module: rr_arbiter2, the 2-way round-robin grant logic (req_valid, last_grant -> grant one-hot).
- Result mux stays inline.

Test Plan:
- Single req0: A=16'd7, B=16'd5, FUN=4'b0000 (add), ALU model returns 12 -> accepted at T; rsp_valid at T+3; rsp_id=0; rsp_data=32'd12; carry=0.
- Both valid every cycle, FUN=4'b0100 -> grants 0,1,0,1 in order; rsp_id alternates 0,1,0,1; a new req_ready appears only after each rsp handshake.
- CMP op, req1: A=9, B=9, FUN=4'b1001, ALU returns CMP_OUT=16'h0001, flag=1 -> rsp_data=32'h0000_0001; rsp_flag=1; rsp_carry=0.
- rsp_ready held low 10 cycles after rsp_valid -> rsp_* stable all 10 cycles; req_ready stays 0; alu_a/b/fun unchanged.
- rst asserted during EXEC -> next cycle all outputs 0 and state IDLE; a req1-only request after reset is granted; a subsequent tie goes to req0.
- ALU_LATENCY=3 build -> rsp_valid at T+5 and data matches the ALU output 3 cycles after the inputs were applied.
